hex_monitor: RTL and testbench

Read-back end of the seven-segment display path: samples the six active-low segment buses (HEX5..HEX0), decodes each legal glyph back to its 4-bit hex value and filters glitches with a per-digit stability counter. Each committed digit change is logged as an event in a small first-word-fall-through FIFO. It sits beside the display driver on the board, or in a bench, for self-checking of what is actually shown.

---
 rtl/hex_monitor_if.sv | 28 ++
 rtl/hex_monitor.sv | 154 +++++++++++++++
 tb/tb_hex_monitor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_monitor_if.sv
// Bundle of segment inputs, event-FIFO read port and committed-state outputs of hex_monitor.
// The master side drives the segment buses and rd_en; the slave side is the monitor.
interface hex_monitor_if #(
  parameter int unsigned FifoDepth = 8
);
  localparam int unsigned CountW = $clog2(FifoDepth) + 1;

  logic [5:0][6:0]    hex;       // [d] = HEXd, active-low, bit 6 = g .. bit 0 = a
  logic               rd_en;
  logic               ev_valid;
  logic [2:0]         ev_digit;
  logic [3:0]         ev_value;
  logic               ev_err;
  logic [23:0]        values;
  logic [5:0]         invalid;
  logic [CountW-1:0]  count;
  logic               overflow;

  modport master (
    output hex, rd_en,
    input  ev_valid, ev_digit, ev_value, ev_err, values, invalid, count, overflow
  );

  modport slave (
    input  hex, rd_en,
    output ev_valid, ev_digit, ev_value, ev_err, values, invalid, count, overflow
  );
endinterface

// File: rtl/hex_monitor.sv
// Seven-segment read-back monitor: per-digit glitch filter, glyph decode and
// an event FIFO (first-word-fall-through) logging every committed digit change.
module hex_monitor #(
  parameter int unsigned StableCycles = 4,
  parameter int unsigned FifoDepth    = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  hex_monitor_if.slave  mon_io
);
  localparam int unsigned CntW   = (StableCycles > 2) ? $clog2(StableCycles) : 1;
  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [CntW-1:0]   CntMax = CntW'(StableCycles - 1);
  localparam logic [CntW-1:0]   CntPre = CntW'(StableCycles - 2);
  localparam logic [CountW-1:0] Full   = CountW'(FifoDepth);
  localparam logic [6:0]        Blank  = 7'h7F;

  // Returns {err, value}; illegal patterns decode to value 0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h10:   decode = 5'h09;
      7'h08:   decode = 5'h0A;
      7'h03:   decode = 5'h0B;
      7'h46:   decode = 5'h0C;
      7'h21:   decode = 5'h0D;
      7'h06:   decode = 5'h0E;
      7'h0E:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [5:0][6:0]      cand_q, cand_d;
  logic [5:0][6:0]      comm_q, comm_d;
  logic [5:0][CntW-1:0] cnt_q, cnt_d;
  logic [5:0]           pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           mem_q [FifoDepth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountW-1:0]    count_q, count_d;

  logic                 found, pop, push;
  logic [2:0]           push_sel;
  logic [5:0]           grant;
  logic [4:0]           push_dec;
  logic [7:0]           push_data;
  logic [7:0]           head;
  logic [5:0][4:0]      comm_dec;

  always_comb begin
    found    = 1'b0;
    push_sel = '0;
    for (int d = 0; d < 6; d++) begin
      if (pend_q[d] && !found) begin
        found    = 1'b1;
        push_sel = 3'(d);
      end
    end

    pop  = mon_io.rd_en && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push = found && ((count_q != Full) || pop);

    grant = '0;
    if (push) begin
      grant[push_sel] = 1'b1;
    end
    push_dec  = decode(comm_q[push_sel]);
    push_data = {push_sel, push_dec};

    cand_d = cand_q;
    cnt_d  = cnt_q;
    comm_d = comm_q;
    pend_d = pend_q & ~grant;
    ovf_d  = ovf_q;
    for (int d = 0; d < 6; d++) begin
      if (mon_io.hex[d] != cand_q[d]) begin
        cand_d[d] = mon_io.hex[d];
        cnt_d[d]  = '0;
      end else if (cnt_q[d] != CntMax) begin
        cnt_d[d] = cnt_q[d] + 1'b1;
        if ((cnt_q[d] == CntPre) && (cand_q[d] != comm_q[d])) begin
          comm_d[d] = cand_q[d];
          // An unpushed event for this digit is overwritten by the newer one.
          if (pend_d[d]) begin
            ovf_d = 1'b1;
          end
          pend_d[d] = 1'b1;
        end
      end
    end

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + CountW'(push) - CountW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cand_q  <= {6{Blank}};
      comm_q  <= {6{Blank}};
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      cand_q  <= cand_d;
      comm_q  <= comm_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  always_comb begin
    head            = mem_q[rptr_q];
    mon_io.ev_valid = (count_q != '0);
    mon_io.ev_digit = mon_io.ev_valid ? head[7:5] : 3'd0;
    mon_io.ev_err   = mon_io.ev_valid ? head[4]   : 1'b0;
    mon_io.ev_value = mon_io.ev_valid ? head[3:0] : 4'd0;
    mon_io.count    = count_q;
    mon_io.overflow = ovf_q;
  end

  always_comb begin
    mon_io.values  = '0;
    mon_io.invalid = '0;
    for (int d = 0; d < 6; d++) begin
      comm_dec[d]             = decode(comm_q[d]);
      mon_io.values[4*d +: 4] = comm_dec[d][3:0];
      mon_io.invalid[d]       = comm_dec[d][4];
    end
  end
endmodule

// File: tb/tb_hex_monitor.sv
// Bench for hex_monitor: run-length/queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized segment traffic.
module tb_hex_monitor;
  localparam int unsigned S = 4;
  localparam int unsigned D = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0][6:0] hex_drv;
  logic            rd_drv;
  bit              chk_en;
  int              n_tests = 0;
  int              n_fail  = 0;

  always #5 clk = ~clk;

  hex_monitor_if #(.FifoDepth(D)) mon_if ();
  assign mon_if.hex   = hex_drv;
  assign mon_if.rd_en = rd_drv;

  hex_monitor #(.StableCycles(S), .FifoDepth(D)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .mon_io  (mon_if)
  );

  typedef struct packed {
    logic [2:0] d;
    logic       e;
    logic [3:0] v;
  } ev_t;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: committed pattern, run length of the current raw pattern, pending flags.
  ev_t        mq [$];
  logic [6:0] m_last [6];
  int         m_run  [6];
  logic [6:0] m_comm [6];
  bit         m_pend [6];
  bit         m_ovf;
  bit         m_pop;
  int         m_g;
  ev_t        m_ev;

  function automatic ev_t mk(input int d, input logic [6:0] p);
    ev_t e;
    e.d = 3'(d);
    e.e = 1'b1;
    e.v = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) begin
        e.e = 1'b0;
        e.v = 4'(i);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      for (int d = 0; d < 6; d++) begin
        m_last[d] = 7'h7F;
        m_run[d]  = 1;
        m_comm[d] = 7'h7F;
        m_pend[d] = 1'b0;
      end
      m_ovf = 1'b0;
    end else begin
      m_pop = rd_drv && (mq.size() > 0);
      m_g   = -1;
      for (int d = 0; d < 6; d++) if (m_pend[d] && m_g < 0) m_g = d;
      if (m_g >= 0) m_ev = mk(m_g, m_comm[m_g]);
      if (m_pop) void'(mq.pop_front());
      if (m_g >= 0 && (mq.size() < D)) begin
        mq.push_back(m_ev);
        m_pend[m_g] = 1'b0;
      end
      for (int d = 0; d < 6; d++) begin
        if (hex_drv[d] == m_last[d]) begin
          if (m_run[d] < S) begin
            m_run[d]++;
            if (m_run[d] == S && m_last[d] != m_comm[d]) begin
              m_comm[d] = m_last[d];
              if (m_pend[d]) m_ovf = 1'b1;
              m_pend[d] = 1'b1;
            end
          end
        end else begin
          m_last[d] = hex_drv[d];
          m_run[d]  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ev_t         h;
      logic [23:0] ev_vals;
      logic [5:0]  ev_inv;
      h = (mq.size() > 0) ? mq[0] : '0;
      for (int d = 0; d < 6; d++) begin
        ev_t c;
        c = mk(d, m_comm[d]);
        ev_vals[4*d +: 4] = c.v;
        ev_inv[d]         = c.e;
      end
      check("ev_valid", 32'(mon_if.ev_valid), 32'(mq.size() > 0));
      check("ev_digit", 32'(mon_if.ev_digit), 32'(h.d));
      check("ev_value", 32'(mon_if.ev_value), 32'(h.v));
      check("ev_err",   32'(mon_if.ev_err),   32'(h.e));
      check("values",   32'(mon_if.values),   32'(ev_vals));
      check("invalid",  32'(mon_if.invalid),  32'(ev_inv));
      check("count",    32'(mon_if.count),    32'(mq.size()));
      check("overflow", 32'(mon_if.overflow), 32'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input int d, input int v, input int e);
    check("pop_valid", 32'(mon_if.ev_valid), 32'd1);
    check("pop_digit", 32'(mon_if.ev_digit), 32'(d));
    check("pop_value", 32'(mon_if.ev_value), 32'(v));
    check("pop_err",   32'(mon_if.ev_err),   32'(e));
    rd_drv = 1'b1;
    step(1);
    rd_drv = 1'b0;
  endtask

  int hold [6];

  initial begin
    hex_drv = {6{7'h7F}};
    rd_drv  = 1'b0;
    reset   = 1'b1;
    chk_en  = 1'b0;
    step(2);
    reset  = 1'b0;
    chk_en = 1'b1;

    step(20);
    check("idle_invalid", 32'(mon_if.invalid),  32'h3F);
    check("idle_values",  32'(mon_if.values),   32'h0);
    check("idle_count",   32'(mon_if.count),    32'h0);
    check("idle_valid",   32'(mon_if.ev_valid), 32'h0);

    hex_drv[0] = 7'h30;
    step(4);
    check("commit_valid_early", 32'(mon_if.ev_valid),    32'd0);
    check("commit_value",       32'(mon_if.values[3:0]), 32'd3);
    check("commit_invalid0",    32'(mon_if.invalid[0]),  32'd0);
    step(1);
    pop_expect(0, 3, 0);
    check("after_pop_count", 32'(mon_if.count), 32'd0);

    hex_drv[2] = 7'h24;
    step(3);
    hex_drv[2] = 7'h7F;
    step(10);
    check("pulse_count",  32'(mon_if.count),        32'd0);
    check("pulse_values", 32'(mon_if.values[11:8]), 32'd0);

    hex_drv[5] = 7'h0E;
    hex_drv[1] = 7'h19;
    hex_drv[3] = 7'h55;
    step(5);
    check("multi_count1", 32'(mon_if.count), 32'd1);
    step(1);
    check("multi_count2", 32'(mon_if.count), 32'd2);
    step(1);
    check("multi_count3", 32'(mon_if.count),      32'd3);
    check("multi_inv3",   32'(mon_if.invalid[3]), 32'd1);
    pop_expect(1, 4'h4, 0);
    pop_expect(3, 4'h0, 1);
    pop_expect(5, 4'hF, 0);

    for (int i = 0; i < 12; i++) begin
      hex_drv[0] = (i % 2 == 0) ? 7'h40 : 7'h79;
      step(6);
    end
    step(5);
    check("full_count",    32'(mon_if.count),    32'd8);
    check("full_overflow", 32'(mon_if.overflow), 32'd1);
    pop_expect(0, 0, 0);
    check("full_pushpop_count", 32'(mon_if.count), 32'd8);
    pop_expect(0, 1, 0);
    pop_expect(0, 0, 0);
    pop_expect(0, 1, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_count",    32'(mon_if.count),    32'd0);
    check("rst_valid",    32'(mon_if.ev_valid), 32'd0);
    check("rst_overflow", 32'(mon_if.overflow), 32'd0);

    for (int d = 0; d < 6; d++) hold[d] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 6; d++) begin
        if (hold[d] == 0) begin
          hold[d]    = $urandom_range(1, 8);
          hex_drv[d] = ($urandom % 4 != 0) ? glyph[$urandom % 16] : 7'($urandom);
        end else begin
          hold[d]--;
        end
      end
      if ((c / 500) % 2 == 0) rd_drv = ($urandom % 6 == 0);
      else                    rd_drv = ($urandom % 2 == 0);
      reset = ($urandom % 700 == 0);
      step(1);
    end
    reset  = 1'b0;
    rd_drv = 1'b0;
    step(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
